prim_arbiter_wrr: RTL and testbench

PRIM_ARBITER_WRR -- requirements
Module: prim_arbiter_wrr

---
 rtl/prim_arbiter_wrr.sv | 137 +++++++++++++
 tb/tb_prim_arbiter_wrr.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/prim_arbiter_wrr.sv
// Weighted round-robin arbiter with per-port grant quotas and a sticky lock.
// The lock holds the selection while the sink stalls (valid_o & ~ready_i).
// Combinational select/grant path; state is owner, credit, lock and lock_idx.
module prim_arbiter_wrr #(
   parameter int N          = 8,
   parameter int DW         = 32,
   parameter bit EnDataPort = 1'b1,
   parameter int WW         = 4,
   localparam int IdxW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [N-1:0]      req_i,
   input  logic [N*DW-1:0]   data_i,
   input  logic [N*WW-1:0]   weight_i,
   output logic [N-1:0]      gnt_o,
   output logic [IdxW-1:0]   idx_o,
   output logic              valid_o,
   output logic [DW-1:0]     data_o,
   input  logic              ready_i
);

   if (N == 1) begin : g_bypass
      // A single requester needs no arbitration and keeps no state.
      assign valid_o = req_i[0];
      assign gnt_o   = req_i[0] & ready_i;
      assign idx_o   = '0;
      assign data_o  = EnDataPort ? data_i[DW-1:0] : {DW{1'b1}};

   end else begin : g_arb
      logic [IdxW-1:0] owner_q, owner_d;
      logic [WW-1:0]   credit_q, credit_d;
      logic            lock_q, lock_d;
      logic [IdxW-1:0] lock_idx_q, lock_idx_d;

      logic            valid;
      logic            grant;
      logic            lock_hit;
      logic            owner_hit;
      logic [IdxW-1:0] search_idx;
      logic [IdxW-1:0] sel_idx;
      logic [WW-1:0]   sel_weight;

      assign valid     = |req_i;
      assign grant     = valid & ready_i;
      // A lock only holds while its requester keeps asking; a withdrawn
      // request falls straight through to owner/search in the same cycle.
      assign lock_hit  = lock_q & req_i[lock_idx_q];
      assign owner_hit = req_i[owner_q] & (credit_q != '0);

      // Round-robin search starting just after the owner, owner itself last.
      always_comb begin
         // NOTE: every variable assigned in always_comb gets a default first,
         // so no path leaves it unassigned and no latch is inferred.
         int unsigned cand;
         logic        found;
         search_idx = '0;
         found      = 1'b0;
         cand       = 0;
         for (int off = 1; off <= N; off++) begin
            cand = (int'(owner_q) + off) % N;
            if (!found && req_i[cand]) begin
               found      = 1'b1;
               search_idx = IdxW'(cand);
            end
         end
      end

      // Priority: held lock, then owner with remaining credit, then search.
      always_comb begin
         sel_idx = '0;
         if (valid) begin
            if (lock_hit) begin
               sel_idx = lock_idx_q;
            end else if (owner_hit) begin
               sel_idx = owner_q;
            end else begin
               sel_idx = search_idx;
            end
         end
      end

      // Output drive: one-hot grant only when the sink accepts.
      always_comb begin
         gnt_o = '0;
         if (grant) begin
            gnt_o[sel_idx] = 1'b1;
         end
      end

      assign valid_o    = valid;
      assign idx_o      = sel_idx;
      assign data_o     = EnDataPort ? data_i[sel_idx*DW +: DW] : {DW{1'b1}};
      assign sel_weight = weight_i[sel_idx*WW +: WW];

      // Turn bookkeeping: weight is sampled only when ownership moves.
      always_comb begin
         owner_d    = owner_q;
         credit_d   = credit_q;
         lock_d     = lock_q;
         lock_idx_d = lock_idx_q;
         if (grant) begin
            lock_d = 1'b0;
            if (sel_idx == owner_q) begin
               credit_d = (credit_q == '0) ? '0 : credit_q - 1'b1;
            end else begin
               owner_d  = sel_idx;
               // A zero weight still earns the one grant just given.
               credit_d = (sel_weight == '0) ? '0 : sel_weight - 1'b1;
            end
         end else if (valid) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
         end else begin
            lock_d = 1'b0;
         end
      end

      // State register; reset leaves owner at N-1 so the first search starts at 0.
      always_ff @(posedge clk_i or posedge rst_i) begin
         // NOTE: flops use non-blocking assignment so every register samples
         // the pre-edge value of the others, independent of statement order.
         if (rst_i) begin
            owner_q    <= IdxW'(N - 1);
            credit_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
         end else begin
            owner_q    <= owner_d;
            credit_q   <= credit_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
         end
      end
   end

endmodule

// File: tb/tb_prim_arbiter_wrr.sv
// Directed scoreboard bench for prim_arbiter_wrr with N=4.
module tb_prim_arbiter_wrr;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int WW = 4;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [N-1:0]    req_i;
   logic [N*DW-1:0] data_i;
   logic [N*WW-1:0] weight_i;
   logic [N-1:0]    gnt_o;
   logic [1:0]      idx_o;
   logic            valid_o;
   logic [DW-1:0]   data_o;
   logic            ready_i;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string      tag;
      logic       valid;
      logic [1:0] idx;
      logic [3:0] gnt;
      logic [7:0] data;
   } exp_t;

   exp_t sb_q[$];

   prim_arbiter_wrr #(
      .N(N), .DW(DW), .EnDataPort(1'b1), .WW(WW)
   ) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (req_i),
      .data_i   (data_i),
      .weight_i (weight_i),
      .gnt_o    (gnt_o),
      .idx_o    (idx_o),
      .valid_o  (valid_o),
      .data_o   (data_o),
      .ready_i  (ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, push its expectation, compare at negedge,
   // then return just after the next rising edge.
   task automatic step(input string tag, input logic [3:0] req, input logic rdy,
                       input logic ev, input logic [1:0] ei);
      exp_t e;
      exp_t o;
      req_i   = req;
      ready_i = rdy;
      e.tag   = tag;
      e.valid = ev;
      e.idx   = ev ? ei : 2'd0;
      e.gnt   = (ev && rdy) ? (4'b0001 << ei) : 4'b0000;
      e.data  = 8'hA0 + {6'd0, e.idx};
      sb_q.push_back(e);
      @(negedge clk_i);
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 0, 1);
      end else begin
         o = sb_q.pop_front();
         check({o.tag, "_valid"}, valid_o, o.valid);
         check({o.tag, "_idx"},   idx_o,   o.idx);
         check({o.tag, "_gnt"},   gnt_o,   o.gnt);
         if (o.valid) check({o.tag, "_data"}, data_o, o.data);
      end
      // Structural properties every cycle.
      check({tag, "_onehot0"}, $onehot0(gnt_o), 1);
      if (|gnt_o) check({tag, "_gnt_needs_rdy_vld"}, ready_i & valid_o, 1);
      if (valid_o && ready_i)
         check({tag, "_gnt_at_idx"}, gnt_o[idx_o] & req_i[idx_o], 1);
      if (valid_o)
         check({tag, "_data_at_idx"}, data_o, data_i[idx_o*DW +: DW]);
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse_reset();
      rst_i = 1'b1;
      #1;
      rst_i = 1'b0;
   endtask

   function automatic logic [N*WW-1:0] weights(input int w3, input int w2,
                                               input int w1, input int w0);
      return {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] seq_a [8];
      logic [1:0] seq_b [5];
      seq_a = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
      seq_b = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

      rst_i    = 1'b1;
      req_i    = '0;
      ready_i  = 1'b0;
      data_i   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      weight_i = weights(1, 1, 1, 2);
      #1;

      // Outputs during reset are a pure function of inputs and reset state.
      step("rst_idle", 4'b0000, 1'b1, 1'b0, 2'd0);
      step("rst_all",  4'b1111, 1'b1, 1'b1, 2'd0);
      step("rst_p3",   4'b1000, 1'b0, 1'b1, 2'd3);
      rst_i = 1'b0;

      // Weights {2,1,1,1}, everyone requesting.
      for (int i = 0; i < 8; i++) step($sformatf("wrr_%0d", i), 4'b1111, 1'b1, 1'b1, seq_a[i]);

      // Zero weights behave as one grant per turn.
      weight_i = weights(0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step($sformatf("w0_%0d", i), 4'b1111, 1'b1, 1'b1, seq_b[i]);

      // Stall holds selection; grant only when ready returns.
      weight_i = weights(1, 1, 1, 1);
      pulse_reset();
      step("stall_0", 4'b0101, 1'b0, 1'b1, 2'd0);
      step("stall_1", 4'b0101, 1'b0, 1'b1, 2'd0);
      step("stall_2", 4'b0111, 1'b0, 1'b1, 2'd0);
      step("stall_3", 4'b0111, 1'b1, 1'b1, 2'd0);

      // Lock beats the round-robin search (owner 0, no credit).
      step("lock_set",  4'b0001, 1'b0, 1'b1, 2'd0);
      step("lock_hold", 4'b0011, 1'b0, 1'b1, 2'd0);
      step("lock_gnt",  4'b0011, 1'b1, 1'b1, 2'd0);
      step("lock_free", 4'b0011, 1'b1, 1'b1, 2'd1);

      // Locked requester withdraws: fall through in the same cycle.
      step("wd_lock",  4'b0100, 1'b0, 1'b1, 2'd2);
      step("wd_drop",  4'b0001, 1'b1, 1'b1, 2'd0);
      step("wd_clear", 4'b0110, 1'b1, 1'b1, 2'd1);

      // Owner withdraws mid-turn: next port becomes owner with fresh credit.
      weight_i = weights(3, 3, 3, 3);
      step("own_p0",   4'b0001, 1'b1, 1'b1, 2'd0);
      step("own_p1",   4'b0010, 1'b1, 1'b1, 2'd1);
      step("own_move", 4'b1101, 1'b1, 1'b1, 2'd2);
      step("own_c1",   4'b1111, 1'b1, 1'b1, 2'd2);
      step("own_c0",   4'b1111, 1'b1, 1'b1, 2'd2);
      step("own_next", 4'b1111, 1'b1, 1'b1, 2'd3);

      // Reset mid-turn discards owner and credit.
      weight_i = weights(2, 2, 2, 2);
      step("mid_p2", 4'b0100, 1'b1, 1'b1, 2'd2);
      pulse_reset();
      step("mid_rst", 4'b1111, 1'b1, 1'b1, 2'd0);

      check("sb_drained", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
